// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// instruction size and default reset PC.
package fetch_pkg;

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StDrop,
        StHalt
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_out_buf.sv
// Single-entry valid/ready output register holding a fetched word and its PC.
// Flush has priority over load, and load has priority over drain.
module fetch_out_buf #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         flush,
    input  logic [31:0]  load_instr,
    input  logic [N-1:0] load_pc,
    input  logic         ready,
    output logic         valid,
    output logic [31:0]  instr,
    output logic [N-1:0] instr_pc
);

    logic         valid_q;
    logic [31:0]  instr_q;
    logic [N-1:0] pc_q;

    // Buffer register: flush, reload or drain on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            instr_q <= load_instr;
            pc_q    <= load_pc;
        end else if (valid_q && ready) begin
            valid_q <= 1'b0;
        end
    end

    assign valid    = valid_q;
    assign instr    = instr_q;
    assign instr_pc = pc_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to
// instruction memory, buffers the returned word and accepts branch redirects.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to halt on a misaligned
// redirect target; otherwise the target is silently word-aligned.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC)
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [31:0]  instr,
    output logic [N-1:0] instr_pc,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    output logic         misalign_err
);

    fetch_state_e state_q, state_d;
    logic [N-1:0] fetch_pc_q, fetch_pc_d;
    logic         misalign_q, misalign_d;
    logic         buf_load, buf_flush;
    logic         trap;
    logic [N-1:0] redirect_pc;

    // Low target bits are dropped; a misaligned target either traps or is rounded down.
    assign redirect_pc = {branch_target[N-1:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    assign trap = branch_taken && (branch_target[1:0] != 2'b00);
`else
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^branch_target[1:0];
    assign trap = 1'b0;
`endif

    // Next-state, PC and request logic; a redirect overrides every other event.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        misalign_d = misalign_q;
        imem_req   = 1'b0;
        buf_load   = 1'b0;
        buf_flush  = 1'b0;

        case (state_q)
            StFetch: begin
                imem_req = !instr_valid || instr_ready;
                if (imem_req) state_d = StWait;
            end
            StWait: begin
                if (imem_rvalid) begin
                    buf_load   = 1'b1;
                    fetch_pc_d = fetch_pc_q + N'(INSTR_BYTES);
                    state_d    = StFetch;
                end
            end
            StDrop: begin
                if (imem_rvalid) state_d = StFetch;
            end
            StHalt: begin
                buf_flush = 1'b1;
            end
            default: state_d = StFetch;
        endcase

        if (branch_taken && (state_q != StHalt)) begin
            buf_load  = 1'b0;
            buf_flush = 1'b1;
            if (trap) begin
                // No request leaves in the trapping cycle.
                imem_req   = 1'b0;
                misalign_d = 1'b1;
                state_d    = StHalt;
            end else begin
                fetch_pc_d = redirect_pc;
                case (state_q)
                    StFetch: state_d = imem_req ? StDrop : StFetch;
                    StWait:  state_d = imem_rvalid ? StFetch : StDrop;
                    default: state_d = StDrop;
                endcase
            end
        end

        if (rst) imem_req = 1'b0;
    end

    // State, PC and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            fetch_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_out_buf #(
        .N (N)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .flush      (buf_flush),
        .load_instr (imem_rdata),
        .load_pc    (fetch_pc_q),
        .ready      (instr_ready),
        .valid      (instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc)
    );

    assign imem_addr    = fetch_pc_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: a latency-programmable memory model
// pushes expected words as it returns them; the handshake pops and compares.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        misalign_err;

    fetch_pc_unit #(
        .N        (32),
        .RESET_PC (RST_PC)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .misalign_err  (misalign_err)
    );

    // Second instance to exercise PC wrap from the top of the address space.
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic        w_err;
    logic [31:0] w_addrs[$];
    bit          w_pend;

    fetch_pc_unit #(
        .N        (32),
        .RESET_PC (32'hFFFF_FFFC)
    ) u_dut_wrap (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_rvalid   (w_rvalid),
        .imem_rdata    (w_rdata),
        .instr_valid   (w_valid),
        .instr_ready   (1'b1),
        .instr         (w_instr),
        .instr_pc      (w_pc),
        .branch_taken  (1'b0),
        .branch_target (32'h0),
        .misalign_err  (w_err)
    );

    initial begin
        w_rvalid = 1'b0;
        w_rdata  = 32'h0000_0013;
        w_pend   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            w_rvalid = w_pend;
            w_pend   = 1'b0;
            #1;
            if (w_req && !rst) begin
                if (w_addrs.size() < 2) w_addrs.push_back(w_addr);
                w_pend = 1'b1;
            end
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2001_0005;
            32'h0000_0004: return 32'h1022_0001;
            default:       return a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } item_t;

    item_t       sb[$];
    logic [31:0] hs_pcs[$];
    logic [31:0] hs_words[$];
    int          hs_cycles[$];

    int          mem_lat = 1;
    bit          pending, pend_live;
    logic [31:0] pend_addr;
    int          pend_cnt;
    logic [31:0] exp_pc;
    bit          halted;
    int          cyc = 0;

    bit          drv_rst, drv_ready, drv_br;
    logic [31:0] drv_tgt;

    logic        obs_req, obs_valid, obs_err;
    logic [31:0] obs_addr, obs_instr, obs_pc;

    // One clock cycle: drive inputs, run memory model, sample, advance.
    task automatic cycle();
        bit          fired, fired_live;
        logic [31:0] f_addr;
        item_t       it;
        fired      = 1'b0;
        fired_live = 1'b0;
        f_addr     = '0;
        if (pending) begin
            if (pend_cnt == 0) begin
                fired      = 1'b1;
                fired_live = pend_live;
                f_addr     = pend_addr;
                pending    = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        rst           = drv_rst;
        imem_rvalid   = fired;
        imem_rdata    = fired ? mem_word(f_addr) : 32'hDEAD_BEEF;
        instr_ready   = drv_ready;
        branch_taken  = drv_br;
        branch_target = drv_tgt;
        #1;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = instr_valid;
        obs_instr = instr;
        obs_pc    = instr_pc;
        obs_err   = misalign_err;
        if (drv_rst) begin
            check("req_in_reset", {31'b0, imem_req}, 32'd0);
            pending = 1'b0;
            sb.delete();
            exp_pc  = RST_PC;
            halted  = 1'b0;
        end else begin
            if (imem_req) begin
                check("imem_addr", imem_addr, exp_pc);
                check("one_outstanding", {31'b0, pending}, 32'd0);
                pending   = 1'b1;
                pend_addr = imem_addr;
                pend_cnt  = mem_lat - 1;
                pend_live = !drv_br;
            end
            if (instr_valid && instr_ready && !drv_br) begin
                hs_cycles.push_back(cyc);
                hs_pcs.push_back(instr_pc);
                hs_words.push_back(instr);
                if (sb.size() == 0) begin
                    check("stale_instr_valid", {31'b0, instr_valid}, 32'd0);
                end else begin
                    it = sb.pop_front();
                    check("sb_instr", instr, it.word);
                    check("sb_instr_pc", instr_pc, it.pc);
                end
            end
            if (drv_br && !halted) begin
                sb.delete();
                pend_live = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (drv_tgt[1:0] != 2'b00) halted = 1'b1;
                else exp_pc = {drv_tgt[31:2], 2'b00};
`else
                exp_pc = {drv_tgt[31:2], 2'b00};
`endif
            end else if (fired && fired_live) begin
                sb.push_back('{pc: f_addr, word: mem_word(f_addr)});
                exp_pc = f_addr + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int          i;
        int          n0;
        logic [31:0] snap_i, snap_p;

        rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b1;
        branch_taken = 1'b0; branch_target = '0;
        drv_rst = 1'b1; drv_ready = 1'b1; drv_br = 1'b0; drv_tgt = '0;
        pending = 1'b0; pend_live = 1'b0; pend_addr = '0; pend_cnt = 0;
        exp_pc = RST_PC; halted = 1'b0;
        @(posedge clk);
        #1;

        // Reset and state right after it
        cycle();
        cycle();
        drv_rst = 1'b0;
        cycle();
        check("rst_valid", {31'b0, obs_valid}, 32'd0);
        check("rst_instr", obs_instr, 32'd0);
        check("rst_instr_pc", obs_pc, 32'd0);
        check("rst_misalign", {31'b0, obs_err}, 32'd0);
        check("rst_addr", obs_addr, RST_PC);
        check("rst_first_req", {31'b0, obs_req}, 32'd1);

        // Streaming with k = 1 and ready high
        repeat (8) cycle();
        check("first_pc", hs_pcs[0], 32'h0000_0000);
        check("first_word", hs_words[0], 32'h2001_0005);
        check("second_pc", hs_pcs[1], 32'h0000_0004);
        check("second_word", hs_words[1], 32'h1022_0001);
        check("throughput_gap", hs_cycles[1] - hs_cycles[0], 32'd2);

        // Backpressure with a full buffer
        drv_ready = 1'b0;
        i = 0;
        do begin cycle(); i++; end while (!obs_valid && i < 20);
        check("stall_fill", {31'b0, obs_valid}, 32'd1);
        snap_i = obs_instr;
        snap_p = obs_pc;
        repeat (5) begin
            cycle();
            check("stall_no_req", {31'b0, obs_req}, 32'd0);
            check("stall_instr", obs_instr, snap_i);
            check("stall_pc", obs_pc, snap_p);
        end
        drv_ready = 1'b1;
        cycle();
        check("resume_req", {31'b0, obs_req}, 32'd1);
        check("resume_addr", obs_addr, snap_p + 32'd4);

        // Redirect while waiting on a k = 3 response
        mem_lat = 3;
        i = 0;
        do begin cycle(); i++; end while (!obs_req && i < 20);
        check("wait_req_seen", {31'b0, obs_req}, 32'd1);
        drv_br = 1'b1; drv_tgt = 32'h0000_0024;
        cycle();
        drv_br = 1'b0;
        cycle();
        check("redir_valid_clear", {31'b0, obs_valid}, 32'd0);
        i = 0;
        do begin cycle(); i++; end while (!obs_req && i < 20);
        check("redir_req", {31'b0, obs_req}, 32'd1);
        check("redir_addr", obs_addr, 32'h0000_0024);
        n0 = hs_pcs.size();
        mem_lat = 1;
        repeat (8) cycle();
        check("redir_first_pc", hs_pcs[n0], 32'h0000_0024);

        // Redirect in the same cycle as the response
        i = 0;
        do begin cycle(); i++; end while (!obs_req && i < 20);
        drv_br = 1'b1; drv_tgt = 32'h0000_0040;
        cycle();
        drv_br = 1'b0;
        cycle();
        check("drop_valid", {31'b0, obs_valid}, 32'd0);
        check("drop_req", {31'b0, obs_req}, 32'd1);
        check("drop_addr", obs_addr, 32'h0000_0040);

        // Redirect flushes a full, stalled buffer
        drv_ready = 1'b0;
        i = 0;
        do begin cycle(); i++; end while (!obs_valid && i < 20);
        check("flush_fill", {31'b0, obs_valid}, 32'd1);
        drv_br = 1'b1; drv_tgt = 32'h0000_0080;
        cycle();
        drv_br = 1'b0;
        cycle();
        check("flush_valid", {31'b0, obs_valid}, 32'd0);
        check("flush_req", {31'b0, obs_req}, 32'd1);
        check("flush_addr", obs_addr, 32'h0000_0080);
        drv_ready = 1'b1;
        repeat (6) cycle();

        // Misaligned redirect target
        drv_br = 1'b1; drv_tgt = 32'h0000_0009;
        cycle();
        drv_br = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        repeat (6) begin
            cycle();
            check("halt_err", {31'b0, obs_err}, 32'd1);
            check("halt_no_req", {31'b0, obs_req}, 32'd0);
            check("halt_valid", {31'b0, obs_valid}, 32'd0);
        end
        drv_rst = 1'b1;
        cycle();
        drv_rst = 1'b0;
        cycle();
        check("halt_rst_err", {31'b0, obs_err}, 32'd0);
        check("halt_rst_req", {31'b0, obs_req}, 32'd1);
        check("halt_rst_addr", obs_addr, RST_PC);
`else
        i = 0;
        do begin cycle(); i++; end while (!obs_req && i < 20);
        check("misalign_req", {31'b0, obs_req}, 32'd1);
        check("misalign_addr", obs_addr, 32'h0000_0008);
        check("misalign_err_tied", {31'b0, obs_err}, 32'd0);
`endif
        repeat (4) cycle();

        // Wrap from the top of the address space
        check("wrap_first", w_addrs[0], 32'hFFFF_FFFC);
        check("wrap_second", w_addrs[1], 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
